// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared types and constants for the instruction fetch memory.
//   FAULT_*   : 2-bit fault codes reported on resp_fault.
//   NOP_INST  : instruction returned in place of a faulting fetch (addi x0,x0,0).
//   resp_t    : one response buffer entry {inst, addr, fault}; fields are 32 bits
//               wide, the top module narrows them to XLEN / ADDR_W.
package inst_mem_pkg;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;
    localparam logic [1:0] FAULT_PARITY   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [1:0]  fault;
    } resp_t;

endpackage

// File: rtl/inst_mem_resp_fifo.sv
// inst_mem_resp_fifo: 2-entry in-order response buffer.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset (clears entries to 0)
//   i_flush         : discard all stored entries; a same-cycle push is kept
//   i_push, i_data  : write one entry
//   i_pop           : remove head entry
//   o_head          : current head entry (meaningful when o_count != 0)
//   o_count         : number of stored entries, 0..2
// The parent never pushes when full nor pops when empty, so no guards here.
module inst_mem_resp_fifo
    import inst_mem_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_flush,
    input  logic       i_push,
    input  resp_t      i_data,
    input  logic       i_pop,
    output resp_t      o_head,
    output logic [1:0] o_count
);

    resp_t      r_entry [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (i_push) begin
                r_entry[r_wr_ptr] <= i_data;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (i_flush) begin
                // Head jumps to the write slot, so a same-cycle push becomes the only entry.
                r_rd_ptr <= r_wr_ptr;
                r_count  <= {1'b0, i_push};
            end else begin
                if (i_pop)
                    r_rd_ptr <= ~r_rd_ptr;
                r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
            end
        end
    end

    assign o_head  = r_entry[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_mem_fetch.sv
// inst_mem_fetch: byte-addressed instruction memory for the fetch stage.
// Requests are accepted on req_valid & req_ready; the word is read on the
// acceptance edge directly into a 2-entry response buffer, so a response is
// visible one cycle after acceptance and one request per cycle is sustained.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   flush                      : drop outstanding responses (redirect)
//   req_valid/req_ready/req_addr : fetch request handshake, byte address
//   resp_valid/resp_ready      : response handshake
//   resp_inst/resp_addr/resp_fault : fetched word (NOP on fault), its address, fault code
//   load_en/load_idx/load_data : unconditional program-load write port
//   par_flip_en                : (INST_MEM_PARITY_EN only) invert stored parity on a load
// Optional feature: define INST_MEM_PARITY_EN to store an even-parity bit per
// word and report fault 11 on mismatch.
module inst_mem_fetch
    import inst_mem_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int DEPTH  = 128,
    parameter  int ADDR_W = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_inst,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [1:0]        resp_fault,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [XLEN-1:0]   load_data
`ifdef INST_MEM_PARITY_EN
    ,
    input  logic              par_flip_en
`endif
);

    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("inst_mem_fetch: XLEN must be 32");
        end
        if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("inst_mem_fetch: DEPTH must be a power of two in 16..4096");
        end
        if (ADDR_W < IDX_W + 2 || ADDR_W > 32) begin : g_bad_addr_w
            $error("inst_mem_fetch: ADDR_W must cover the memory and be at most 32");
        end
    endgenerate

    // ---------------- storage ----------------
`ifdef INST_MEM_PARITY_EN
    // Never-loaded words must read back as zero with valid parity.
    logic [XLEN-1:0]  r_mem [DEPTH] = '{default: '0};
    logic [DEPTH-1:0] r_par = '0;
`else
    logic [XLEN-1:0]  r_mem [DEPTH];
`endif

    // Independent of reset/flush: program load is never dropped.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_idx] <= load_data;
`ifdef INST_MEM_PARITY_EN
            r_par[load_idx] <= (^load_data) ^ par_flip_en;
`endif
        end
    end

    // ---------------- request side ----------------
    logic [IDX_W-1:0] w_idx;
    logic [XLEN-1:0]  w_rd_word;
    logic [1:0]       w_fault;
    logic [1:0]       w_count;
    logic             w_push;
    logic             w_pop;
    resp_t            w_push_entry;
    resp_t            w_head;

    assign w_idx     = req_addr[IDX_W+1:2];
    // Sampled on the acceptance edge; a same-edge load is not yet visible (read-before-write).
    assign w_rd_word = r_mem[w_idx];

    always_comb begin
        w_fault = FAULT_NONE;
        if (req_addr[1:0] != 2'b00)
            w_fault = FAULT_MISALIGN;
        else if ((req_addr >> (IDX_W + 2)) != '0)
            w_fault = FAULT_RANGE;
`ifdef INST_MEM_PARITY_EN
        else if ((^w_rd_word) != r_par[w_idx])
            w_fault = FAULT_PARITY;
`endif
    end

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.inst  = (w_fault == FAULT_NONE) ? 32'(w_rd_word) : NOP_INST;
        w_push_entry.addr  = 32'(req_addr);
        w_push_entry.fault = w_fault;
    end

    // Occupancy is the buffer count only: the read lands in a buffer slot on
    // the acceptance edge. No path from resp_ready into req_ready.
    assign req_ready = (w_count < 2'd2) & ~reset;
    assign w_push    = req_valid & req_ready;
    assign w_pop     = resp_valid & resp_ready;

    inst_mem_resp_fifo u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // ---------------- response side ----------------
    assign resp_valid = (w_count != 2'd0);
    assign resp_inst  = w_head.inst[XLEN-1:0];
    assign resp_addr  = w_head.addr[ADDR_W-1:0];
    assign resp_fault = w_head.fault;

endmodule
